shift_unit: RTL and testbench
=============================

# shift_unit

Iterative multicycle shifter for the multicycle processor datapath. It sits directly downstream of the ALU control block and consumes its 3-bit `SHIFTER_control` code, the operand and the shift amount. It shifts one bit position per clock and signals completion with a one-cycle `done` pulse, so the main control FSM can wait on `busy`/`done` before writing the result to the register file.

## Interface
- `WIDTH`, default 32: data width.
- `SHAMT_W`, default 5: shift-amount width, which is clog2(WIDTH).
- `clk`, in, 1: clock. Everything updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request strobe. Sampled only in IDLE.
- `shift_op`, in, 3: operation code, driven by the `SHIFTER_control` output of the ALU control block.
- `data_in`, in, WIDTH: operand.
- `shamt`, in, SHAMT_W: shift amount.
- `data_out`, out, WIDTH: shift register contents and result.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse marking that the result is valid.

## Operation
- Op encoding:
  - 000 NOP
  - 001 LOAD
  - 010 SLL
  - 011 SRL
  - 100 SRA
  - 101 ROR
  - 110 ROL
  - 111 reserved
- Reset values: state IDLE, `data_out` = 0, internal count = 0, `busy` = 0, `done` = 0.
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 with a NOP or reserved op: ignored. State and `data_out` are unchanged.
  - `start`=1 with LOAD: `data_out` <= `data_in`, go to DONE.
  - `start`=1 with a shift op and `shamt`=0: `data_out` <= `data_in`, go to DONE.
  - `start`=1 with a shift op and `shamt`>0: `data_out` <= `data_in`, latch the op, count <= `shamt`, go to SHIFT.
- SHIFT: each edge applies one 1-bit step of the latched op and decrements count. On the edge where count==1, apply the final step and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- 1-bit step rules:
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, replicate the MSB.
  - ROR: the LSB wraps into the MSB.
  - ROL: the MSB wraps into the LSB.
- While `busy`, the block ignores `start`, `shift_op`, `data_in` and `shamt`. Operands need only be valid in the cycle `start` is sampled.
- `data_out` holds its value after DONE until the next accepted start.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronously) and the partial result is discarded.

## Timing
- Start is accepted at edge E0. `done` is high during the cycle following edge E0+N, where N = `shamt` for shift ops and N = 0 for LOAD or `shamt`=0.
- Total latency from start to the `done` pulse is N+1 edges. The earliest next accepted start is at the edge ending the DONE cycle +1, i.e. the first IDLE cycle.
- `busy` rises after E0 and falls at the edge leaving DONE. `busy` and `done` overlap in the DONE cycle.
- `data_out` is final and stable during the `done` cycle.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `shifter_pkg`:
  - op code constants (SH_NOP … SH_ROL, SH_RSVD)
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE)
  - `WIDTH` and `SHAMT_W` defaults
- Natural sub-module: `shift_step`, a combinational single-bit step with inputs op and value and output next value. It is reused by the SHIFT state.
- Top level contains the FSM, the down-counter and the data register.

## Test plan
- SLL: `data_in`=0x0000_0001, `shamt`=4 -> `data_out`=0x0000_0010; `done` pulses 4 edges after the start edge; `busy` high for 5 cycles.
- SRA vs SRL:
  - `data_in`=0x8000_0000, `shamt`=31, SRA -> 0xFFFF_FFFF, `done` 31 edges after start.
  - Same operand with SRL -> 0x0000_0001.
- Rotates:
  - `data_in`=0x8000_0001, ROL by 1 -> 0x0000_0003.
  - Same operand, ROR by 1 -> 0xC000_0000.
- Zero-latency cases:
  - LOAD 0xDEAD_BEEF -> `data_out`=0xDEAD_BEEF with `done` in the cycle after the start edge.
  - SLL with `shamt`=0 behaves identically.
- Ignored requests:
  - NOP or op 111 with `start`=1 -> no `busy`, `data_out` unchanged.
  - `start` with new operands during SHIFT -> ignored; the result matches the first request.
- Reset at cycle 2 of a `shamt`=10 shift -> `data_out`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge. A start after reset deasserts runs normally.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: op codes, FSM states and
// default widths, plus a small decode helper used by the control FSM.
package shifter_pkg;

   localparam int DEFAULT_WIDTH   = 32;
   localparam int DEFAULT_SHAMT_W = 5;

   // Op codes as produced by the SHIFTER_control output of the ALU control block
   localparam logic [2:0] SH_NOP  = 3'b000;
   localparam logic [2:0] SH_LOAD = 3'b001;
   localparam logic [2:0] SH_SLL  = 3'b010;
   localparam logic [2:0] SH_SRL  = 3'b011;
   localparam logic [2:0] SH_SRA  = 3'b100;
   localparam logic [2:0] SH_ROR  = 3'b101;
   localparam logic [2:0] SH_ROL  = 3'b110;
   localparam logic [2:0] SH_RSVD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == SH_SLL) || (op == SH_SRL) || (op == SH_SRA) ||
             (op == SH_ROR) || (op == SH_ROL);
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of a shift or rotate. Unknown ops pass the
// value through untouched so the caller never sees X-propagation from decode.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] next_value
);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves next_value unassigned (that would infer a latch).
      next_value = value;
      case (op)
         SH_SLL:  next_value = {value[WIDTH-2:0], 1'b0};
         SH_SRL:  next_value = {1'b0, value[WIDTH-1:1]};
         SH_SRA:  next_value = {value[WIDTH-1], value[WIDTH-1:1]};
         SH_ROR:  next_value = {value[0], value[WIDTH-1:1]};
         SH_ROL:  next_value = {value[WIDTH-2:0], value[WIDTH-1]};
         default: next_value = value;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Iterative multicycle shifter: one bit position per clock, busy while not
// IDLE and a one-cycle done pulse once data_out holds the final result.
module shift_unit
   import shifter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         shift_op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy,
   output logic               done
);

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [WIDTH-1:0]   step_value;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op         (op_q),
      .value      (data_q),
      .next_value (step_value)
   );

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= SH_NOP;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      data_d  = data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (shift_op == SH_LOAD) begin
                  data_d  = data_in;
                  state_d = ST_DONE;
               end else if (is_shift_op(shift_op)) begin
                  data_d  = data_in;
                  op_d    = shift_op;
                  count_d = shamt;
                  // A zero shift amount is just a load; skip the SHIFT state entirely
                  state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            data_d  = step_value;
            count_d = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign data_out = data_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit: results, latencies, ignored
// requests and asynchronous reset in the middle of a shift.
module tb_shift_unit;
   import shifter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  shift_op = SH_NOP;
   logic [31:0] data_in = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .shift_op (shift_op),
      .data_in  (data_in),
      .shamt    (shamt),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request and wait (bounded) for done. edges = -1 on timeout.
   task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                         output int edges, output int busy_cyc);
      @(negedge clk);
      start = 1'b1; shift_op = op; data_in = d; shamt = s;
      @(posedge clk);
      #1;
      start = 1'b0; data_in = ~d; shamt = ~s; shift_op = SH_RSVD;
      edges = -1;
      busy_cyc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want %h", data_out, 32'h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sll();
      int e, b;
      run_op(SH_SLL, 32'h0000_0001, 5'd4, e, b);
      checks++; if (data_out !== 32'h0000_0010) begin failures++; $display("FAIL sll_data: got %h want %h", data_out, 32'h0000_0010); end
      checks++; if (e !== 4) begin failures++; $display("FAIL sll_latency: got %0d want 4", e); end
      checks++; if (b !== 5) begin failures++; $display("FAIL sll_busy_cycles: got %0d want 5", b); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL sll_idle_after: busy %b done %b want 0 0", busy, done); end
      checks++; if (data_out !== 32'h0000_0010) begin failures++; $display("FAIL sll_hold: got %h want %h", data_out, 32'h0000_0010); end
   endtask

   task automatic test_sra_srl();
      int e, b;
      run_op(SH_SRA, 32'h8000_0000, 5'd31, e, b);
      checks++; if (data_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sra_data: got %h want %h", data_out, 32'hFFFF_FFFF); end
      checks++; if (e !== 31) begin failures++; $display("FAIL sra_latency: got %0d want 31", e); end
      run_op(SH_SRL, 32'h8000_0000, 5'd31, e, b);
      checks++; if (data_out !== 32'h0000_0001) begin failures++; $display("FAIL srl_data: got %h want %h", data_out, 32'h0000_0001); end
      checks++; if (e !== 31) begin failures++; $display("FAIL srl_latency: got %0d want 31", e); end
   endtask

   task automatic test_rotates();
      int e, b;
      run_op(SH_ROL, 32'h8000_0001, 5'd1, e, b);
      checks++; if (data_out !== 32'h0000_0003) begin failures++; $display("FAIL rol_data: got %h want %h", data_out, 32'h0000_0003); end
      checks++; if (e !== 1) begin failures++; $display("FAIL rol_latency: got %0d want 1", e); end
      run_op(SH_ROR, 32'h8000_0001, 5'd1, e, b);
      checks++; if (data_out !== 32'hC000_0000) begin failures++; $display("FAIL ror_data: got %h want %h", data_out, 32'hC000_0000); end
      run_op(SH_ROL, 32'h1234_5678, 5'd8, e, b);
      checks++; if (data_out !== 32'h3456_7812) begin failures++; $display("FAIL rol8_data: got %h want %h", data_out, 32'h3456_7812); end
   endtask

   task automatic test_zero_latency();
      int e, b;
      run_op(SH_LOAD, 32'hDEAD_BEEF, 5'd7, e, b);
      checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_data: got %h want %h", data_out, 32'hDEAD_BEEF); end
      checks++; if (e !== 0) begin failures++; $display("FAIL load_latency: got %0d want 0", e); end
      checks++; if (b !== 1) begin failures++; $display("FAIL load_busy_cycles: got %0d want 1", b); end
      run_op(SH_SLL, 32'h1234_5678, 5'd0, e, b);
      checks++; if (data_out !== 32'h1234_5678) begin failures++; $display("FAIL sll0_data: got %h want %h", data_out, 32'h1234_5678); end
      checks++; if (e !== 0) begin failures++; $display("FAIL sll0_latency: got %0d want 0", e); end
   endtask

   task automatic test_ignored();
      logic [2:0] ops [2];
      ops[0] = SH_NOP;
      ops[1] = SH_RSVD;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b1; shift_op = ops[i]; data_in = 32'hAAAA_5555; shamt = 5'd3;
         @(posedge clk);
         #1;
         start = 1'b0;
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_busy op=%b: got %b want 0", ops[i], busy); end
         @(negedge clk);
         checks++; if (data_out !== 32'h1234_5678) begin failures++; $display("FAIL ignored_data op=%b: got %h want %h", ops[i], data_out, 32'h1234_5678); end
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ignored_flags op=%b: busy %b done %b want 0 0", ops[i], busy, done); end
      end
   endtask

   task automatic test_back_to_back();
      int e = -1;
      @(negedge clk);
      start = 1'b1; shift_op = SH_SLL; data_in = 32'h0000_0001; shamt = 5'd8;
      @(posedge clk);
      #1;
      shift_op = SH_SRL; data_in = 32'hFFFF_FFFF; shamt = 5'd2;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == 5) start = 1'b0;
         if (done) begin
            e = k;
            break;
         end
      end
      checks++; if (data_out !== 32'h0000_0100) begin failures++; $display("FAIL busy_restart_data: got %h want %h", data_out, 32'h0000_0100); end
      checks++; if (e !== 8) begin failures++; $display("FAIL busy_restart_latency: got %0d want 8", e); end
   endtask

   task automatic test_reset_mid();
      int e, b;
      @(negedge clk);
      start = 1'b1; shift_op = SH_SLL; data_in = 32'h0000_00FF; shamt = 5'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL midreset_data: got %h want %h", data_out, 32'h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b want 0", done); end
      @(negedge clk);
      reset = 1'b0;
      run_op(SH_SRL, 32'h0000_0100, 5'd4, e, b);
      checks++; if (data_out !== 32'h0000_0010) begin failures++; $display("FAIL post_reset_data: got %h want %h", data_out, 32'h0000_0010); end
      checks++; if (e !== 4) begin failures++; $display("FAIL post_reset_latency: got %0d want 4", e); end
   endtask

   initial begin
      test_reset();
      test_sll();
      test_sra_srl();
      test_rotates();
      test_zero_latency();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
